manchester_tx_scheduler: RTL and testbench
==========================================

Name: manchester_tx_scheduler

Overview:
Packet-level round-robin scheduler that shares the single manchester_escape encoder between NUM_SRC AXI-Stream frame sources. It grants one source at a time and prefixes each frame with the start-of-frame symbol, which the escape stage then escapes. It holds the grant until that source's tlast handshake, then enforces a programmable inter-frame idle gap. It sits directly upstream of manchester_escape in the TX path.

Parameters:
NUM_SRC, 2, number of requesting sources (2..8)
DATA_WIDTH, 8, byte width of every stream
SOF_SYMBOL, 8'hD5, start-of-frame byte inserted before each frame
IFG_CYCLES, 4, idle cycles forced between frames (0 allowed)

Ports:
aclk  in  1  system clock, all logic on rising edge
areset  in  1  synchronous reset, active-high
s_axis_tdata  in  NUM_SRC*DATA_WIDTH  flattened source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tready  out  NUM_SRC  per-source ready
s_axis_tlast  in  NUM_SRC  per-source end of frame
m_axis_tdata  out  DATA_WIDTH  to manchester_escape s_axis_tdata
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready from the escape stage
m_axis_tlast  out  1  output end of frame
grant_id  out  clog2(NUM_SRC) (min 1)  index of the current or most recent granted source
busy  out  1  high in SOF, DATA and GAP states
frame_done  out  1  one-cycle pulse on the output tlast handshake

Behaviour:
- Clock and reset: one clock, aclk. Reset is synchronous and active-high on areset.
- Reset values:
  - state=IDLE; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - s_axis_tready=all 0; grant_id=0; busy=0; frame_done=0.
  - Round-robin pointer last=NUM_SRC-1, so source 0 has first priority.
- Reset mid-frame aborts the frame: no tlast is emitted. The escape stage is reset by the same reset domain.
- FSM states: IDLE, SOF, DATA, GAP.
- IDLE:
  - All readies low; m_axis_tvalid=0.
  - If any s_axis_tvalid bit is high, pick the first requesting index searching last+1, last+2, ... modulo NUM_SRC.
  - Register grant_id, set last to the winner, go to SOF.
  - Latency: request seen at edge N; SOF is valid on the output from cycle N+1.
- SOF:
  - m_axis_tvalid=1, m_axis_tdata=SOF_SYMBOL, m_axis_tlast=0; all s_axis_tready low.
  - Hold until m_axis_tready=1, then go to DATA.
  - A source dropping tvalid while in SOF does not cancel the grant.
- DATA (combinational passthrough, zero added latency):
  - m_axis_tdata = granted source data; m_axis_tvalid = granted tvalid; m_axis_tlast = granted tlast.
  - s_axis_tready[grant_id] = m_axis_tready; all other readies are 0.
  - On a handshake with tlast=1: frame_done pulses in the next cycle (registered). Go to GAP, or to IDLE if IFG_CYCLES=0.
  - Non-granted sources are stalled regardless of their tvalid.
- GAP:
  - m_axis_tvalid=0; counter loads IFG_CYCLES-1 on entry and decrements.
  - At 0, go to IDLE. Total idle cycles on the output = IFG_CYCLES + 1, counting the IDLE arbitration cycle.
- Fairness: with all sources continuously requesting, grants rotate 0,1,...,NUM_SRC-1,0.
- Single-byte frame (tlast on the first data beat) is legal: output is SOF, byte, then GAP.
- SOF_SYMBOL appearing inside frame data is passed unchanged; escaping is the downstream block's job.
- No registered output stage: downstream must not use combinational tready from tvalid loops (manchester_escape satisfies this).

Decomposition:
- Shared header manchester_defs.vh holds:
  - ESCAPE_SYMBOL 8'hE5 and SOF_SYMBOL 8'hD5;
  - state encodings IDLE=2'd0, SOF=2'd1, DATA=2'd2, GAP=2'd3;
  - a CLOG2 helper macro.
- One sub-module: rr_arbiter, a combinational round-robin select. Inputs: req[NUM_SRC], last pointer. Outputs: gnt_valid, gnt_idx. Rotated priority encoder.

Test Plan:
- Single frame, NUM_SRC=2, IFG_CYCLES=4, m_axis_tready=1. Source 0 sends 11,22,33 with tlast on 33. Output must be D5,11,22,33; tlast only on 33; frame_done pulses once; tvalid low for exactly 5 cycles before any next SOF. Chained with manchester_escape, the result must be E5,D5,11,22,33.
- Simultaneous requests, both sources valid from the same cycle. Source 0 sends A1,A2(last); source 1 sends B1(last). Output must be D5,A1,A2, gap, D5,B1; grant_id 0 then 1; s_axis_tready[1]=0 throughout frame A.
- Fairness over 6 back-to-back frames with both sources always requesting: grant_id sequence must be 0,1,0,1,0,1.
- Backpressure: m_axis_tready=0 for 3 cycles during SOF and 2 cycles mid-frame. D5 and the data must each be held stable while stalled, with no duplication or loss. s_axis_tready[grant] must follow m_axis_tready.
- Reset mid-frame: assert areset for 1 cycle after 2 data bytes. Next cycle must show tvalid=0, all readies 0, grant_id=0. The following request from source 1 must be granted with SOF first.
- Edge cases:
  - IFG_CYCLES=0 with a single-byte frame 44(last): output D5,44; the next SOF follows after only the 1 IDLE cycle.
  - Data byte D5 inside a frame is passed through unmodified.

Source files
------------

// File: rtl/manchester_tx_scheduler_pkg.sv
// Shared symbols, FSM encoding and sizing helper for the Manchester TX path.
package manchester_tx_scheduler_pkg;

    localparam logic [7:0] ESCAPE_SYMBOL      = 8'hE5;
    localparam logic [7:0] SOF_SYMBOL_DEFAULT = 8'hD5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/manchester_tx_scheduler_rr_arbiter.sv
// Combinational round-robin select: first requester after the last winner.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (req[IDX_W'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/manchester_tx_scheduler.sv
// Packet round-robin scheduler feeding manchester_escape: SOF prefix,
// grant held to tlast, then a programmable idle gap.
module manchester_tx_scheduler
    import manchester_tx_scheduler_pkg::*;
#(
    parameter int                    NUM_SRC    = 2,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SOF_SYMBOL = DATA_WIDTH'(SOF_SYMBOL_DEFAULT),
    parameter int                    IFG_CYCLES = 4
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_SRC-1:0]               s_axis_tvalid,
    output logic [NUM_SRC-1:0]               s_axis_tready,
    input  logic [NUM_SRC-1:0]               s_axis_tlast,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [clog2_min1(NUM_SRC)-1:0]   grant_id,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int GNT_W = clog2_min1(NUM_SRC);
    localparam int CNT_W = clog2_min1(IFG_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? CNT_W'(IFG_CYCLES - 1) : '0;

    state_t                 state;
    logic [GNT_W-1:0]       last_ptr;
    logic [CNT_W-1:0]       gap_cnt;
    logic                   arb_vld;
    logic [GNT_W-1:0]       arb_idx;
    logic [DATA_WIDTH-1:0]  src_data [NUM_SRC];
    logic [DATA_WIDTH-1:0]  g_tdata;
    logic                   g_tvalid;
    logic                   g_tlast;
    logic                   data_hs;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (GNT_W)
    ) u_arb (
        .req       (s_axis_tvalid),
        .last      (last_ptr),
        .gnt_valid (arb_vld),
        .gnt_idx   (arb_idx)
    );

    assign g_tdata  = src_data[grant_id];
    assign g_tvalid = s_axis_tvalid[grant_id];
    assign g_tlast  = s_axis_tlast[grant_id];
    assign data_hs  = (state == DATA) && g_tvalid && m_axis_tready;
    assign busy     = (state != IDLE);

    // Output mux: DATA is a zero-latency passthrough of the granted source.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (state)
            SOF: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = SOF_SYMBOL;
            end
            DATA: begin
                m_axis_tvalid           = g_tvalid;
                m_axis_tdata            = g_tdata;
                m_axis_tlast            = g_tlast;
                s_axis_tready[grant_id] = m_axis_tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            last_ptr   <= GNT_W'(NUM_SRC - 1);
            grant_id   <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= data_hs && g_tlast;
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        grant_id <= arb_idx;
                        last_ptr <= arb_idx;
                        state    <= SOF;
                    end
                end
                SOF: begin
                    if (m_axis_tready) state <= DATA;
                end
                DATA: begin
                    if (data_hs && g_tlast) begin
                        if (IFG_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_tx_scheduler.sv
// Directed bench for manchester_tx_scheduler (IFG 4 and IFG 0 instances).
module tb_manchester_tx_scheduler;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;

    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid, s_tready, s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [0:0]  grant_id;
    logic        busy, frame_done;

    logic [15:0] z_s_tdata;
    logic [1:0]  z_s_tvalid, z_s_tready, z_s_tlast;
    logic [7:0]  z_m_tdata;
    logic        z_m_tvalid, z_m_tready, z_m_tlast;
    logic [0:0]  z_grant_id;
    logic        z_busy, z_frame_done;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    manchester_tx_scheduler #(
        .NUM_SRC(2), .DATA_WIDTH(8), .SOF_SYMBOL(8'hD5), .IFG_CYCLES(4)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
    );

    manchester_tx_scheduler #(
        .NUM_SRC(2), .DATA_WIDTH(8), .SOF_SYMBOL(8'hD5), .IFG_CYCLES(0)
    ) dut0 (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(z_s_tdata), .s_axis_tvalid(z_s_tvalid),
        .s_axis_tready(z_s_tready), .s_axis_tlast(z_s_tlast),
        .m_axis_tdata(z_m_tdata), .m_axis_tvalid(z_m_tvalid),
        .m_axis_tready(z_m_tready), .m_axis_tlast(z_m_tlast),
        .grant_id(z_grant_id), .busy(z_busy), .frame_done(z_frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic adv();
        @(posedge aclk);
        #1;
    endtask

    // Settle, then check output valid/data/last and the source readies.
    task automatic look(input logic sel, input string tag, input logic ev,
                        input logic [7:0] ed, input logic el, input logic [1:0] er);
        logic       v, l;
        logic [7:0] d;
        logic [1:0] r;
        #1;
        v = sel ? z_m_tvalid : m_tvalid;
        d = sel ? z_m_tdata  : m_tdata;
        l = sel ? z_m_tlast  : m_tlast;
        r = sel ? z_s_tready : s_tready;
        chk({tag, "_vld"}, 32'(v), 32'(ev));
        if (ev) begin
            chk({tag, "_data"}, 32'(d), 32'(ed));
            chk({tag, "_last"}, 32'(l), 32'(el));
        end
        chk({tag, "_rdy"}, 32'(r), 32'(er));
    endtask

    task automatic drive(input logic src, input logic v, input logic [7:0] d, input logic l);
        s_tvalid[src] = v;
        s_tlast[src]  = l;
        if (src) s_tdata[15:8] = d;
        else     s_tdata[7:0]  = d;
    endtask

    task automatic do_reset(input string tag);
        areset   = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        adv();
        look(1'b0, tag, 1'b0, 8'h00, 1'b0, 2'b00);
        chk({tag, "_gid"}, 32'(grant_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
        chk({tag, "_tdata"}, 32'(m_tdata), 32'd0);
        chk({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        areset = 1'b0;
        adv();
    endtask

    initial begin
        s_tdata    = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        z_s_tdata  = '0; z_s_tvalid = '0; z_s_tlast = '0; z_m_tready = 1'b1;

        // Single frame 11,22,33 then idle gap, then single-byte frame carrying D5.
        do_reset("rst1");
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        look(1'b0, "t1_idle", 1'b0, 8'h00, 1'b0, 2'b00); adv();
        look(1'b0, "t1_sof", 1'b1, 8'hD5, 1'b0, 2'b00);
        chk("t1_gid", 32'(grant_id), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1); adv();
        look(1'b0, "t1_d0", 1'b1, 8'h11, 1'b0, 2'b01); adv();
        drive(1'b0, 1'b1, 8'h22, 1'b0);
        look(1'b0, "t1_d1", 1'b1, 8'h22, 1'b0, 2'b01);
        chk("t1_fd_mid", 32'(frame_done), 32'd0); adv();
        drive(1'b0, 1'b1, 8'h33, 1'b1);
        look(1'b0, "t1_d2", 1'b1, 8'h33, 1'b1, 2'b01); adv();
        drive(1'b0, 1'b1, 8'hD5, 1'b1);
        look(1'b0, "t1_gap0", 1'b0, 8'h00, 1'b0, 2'b00);
        chk("t1_fdone", 32'(frame_done), 32'd1); adv();
        look(1'b0, "t1_gap1", 1'b0, 8'h00, 1'b0, 2'b00);
        chk("t1_fdone_off", 32'(frame_done), 32'd0); adv();
        look(1'b0, "t1_gap2", 1'b0, 8'h00, 1'b0, 2'b00); adv();
        look(1'b0, "t1_gap3", 1'b0, 8'h00, 1'b0, 2'b00);
        chk("t1_gap_busy", 32'(busy), 32'd1); adv();
        look(1'b0, "t1_arb", 1'b0, 8'h00, 1'b0, 2'b00);
        chk("t1_arb_busy", 32'(busy), 32'd0); adv();
        look(1'b0, "t1_sof2", 1'b1, 8'hD5, 1'b0, 2'b00);
        chk("t1_gid2", 32'(grant_id), 32'd0); adv();
        look(1'b0, "t1_d5byte", 1'b1, 8'hD5, 1'b1, 2'b01); adv();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        look(1'b0, "t1_end", 1'b0, 8'h00, 1'b0, 2'b00);

        // Simultaneous requests: A1,A2 from source 0, then B1 from source 1.
        do_reset("rst2");
        drive(1'b0, 1'b1, 8'hA1, 1'b0);
        drive(1'b1, 1'b1, 8'hB1, 1'b1);
        look(1'b0, "t2_idle", 1'b0, 8'h00, 1'b0, 2'b00); adv();
        look(1'b0, "t2_sofA", 1'b1, 8'hD5, 1'b0, 2'b00);
        chk("t2_gidA", 32'(grant_id), 32'd0); adv();
        look(1'b0, "t2_A1", 1'b1, 8'hA1, 1'b0, 2'b01); adv();
        drive(1'b0, 1'b1, 8'hA2, 1'b1);
        look(1'b0, "t2_A2", 1'b1, 8'hA2, 1'b1, 2'b01); adv();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int g = 0; g < 5; g++) begin
            look(1'b0, "t2_gap", 1'b0, 8'h00, 1'b0, 2'b00); adv();
        end
        look(1'b0, "t2_sofB", 1'b1, 8'hD5, 1'b0, 2'b00);
        chk("t2_gidB", 32'(grant_id), 32'd1); adv();
        look(1'b0, "t2_B1", 1'b1, 8'hB1, 1'b1, 2'b10); adv();
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        // Fairness: both sources always requesting single-byte frames.
        do_reset("rst3");
        drive(1'b0, 1'b1, 8'h60, 1'b1);
        drive(1'b1, 1'b1, 8'h61, 1'b1);
        for (int f = 0; f < 6; f++) begin
            logic s;
            s = f[0];
            look(1'b0, "t3_idle", 1'b0, 8'h00, 1'b0, 2'b00); adv();
            look(1'b0, "t3_sof", 1'b1, 8'hD5, 1'b0, 2'b00);
            chk("t3_gid", 32'(grant_id), 32'(s)); adv();
            look(1'b0, "t3_data", 1'b1, s ? 8'h61 : 8'h60, 1'b1, s ? 2'b10 : 2'b01); adv();
            for (int g = 0; g < 4; g++) begin
                look(1'b0, "t3_gap", 1'b0, 8'h00, 1'b0, 2'b00); adv();
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        // Backpressure: 3 stalled SOF cycles, 2 stalled data cycles.
        do_reset("rst4");
        m_tready = 1'b0;
        drive(1'b0, 1'b1, 8'h71, 1'b0);
        look(1'b0, "t4_idle", 1'b0, 8'h00, 1'b0, 2'b00); adv();
        for (int k = 0; k < 3; k++) begin
            look(1'b0, "t4_sof_stall", 1'b1, 8'hD5, 1'b0, 2'b00); adv();
        end
        m_tready = 1'b1;
        look(1'b0, "t4_sof_go", 1'b1, 8'hD5, 1'b0, 2'b00); adv();
        look(1'b0, "t4_d71", 1'b1, 8'h71, 1'b0, 2'b01); adv();
        drive(1'b0, 1'b1, 8'h72, 1'b0);
        m_tready = 1'b0;
        look(1'b0, "t4_d72_stall0", 1'b1, 8'h72, 1'b0, 2'b00); adv();
        look(1'b0, "t4_d72_stall1", 1'b1, 8'h72, 1'b0, 2'b00);
        chk("t4_fd_stall", 32'(frame_done), 32'd0); adv();
        m_tready = 1'b1;
        look(1'b0, "t4_d72_go", 1'b1, 8'h72, 1'b0, 2'b01); adv();
        drive(1'b0, 1'b1, 8'h73, 1'b1);
        look(1'b0, "t4_d73", 1'b1, 8'h73, 1'b1, 2'b01); adv();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        look(1'b0, "t4_gap", 1'b0, 8'h00, 1'b0, 2'b00);
        chk("t4_fdone", 32'(frame_done), 32'd1); adv();

        // Reset in the middle of a source-1 frame, then a fresh source-1 frame.
        do_reset("rst5");
        drive(1'b1, 1'b1, 8'h81, 1'b0);
        look(1'b0, "t5_idle", 1'b0, 8'h00, 1'b0, 2'b00); adv();
        look(1'b0, "t5_sof", 1'b1, 8'hD5, 1'b0, 2'b00);
        chk("t5_gid", 32'(grant_id), 32'd1); adv();
        look(1'b0, "t5_d0", 1'b1, 8'h81, 1'b0, 2'b10); adv();
        drive(1'b1, 1'b1, 8'h82, 1'b0);
        look(1'b0, "t5_d1", 1'b1, 8'h82, 1'b0, 2'b10); adv();
        areset = 1'b1;
        drive(1'b1, 1'b1, 8'h83, 1'b0);
        adv();
        areset = 1'b0;
        drive(1'b1, 1'b1, 8'h91, 1'b1);
        look(1'b0, "t5_post", 1'b0, 8'h00, 1'b0, 2'b00);
        chk("t5_post_gid", 32'(grant_id), 32'd0);
        chk("t5_post_busy", 32'(busy), 32'd0);
        chk("t5_post_fdone", 32'(frame_done), 32'd0); adv();
        look(1'b0, "t5_sof2", 1'b1, 8'hD5, 1'b0, 2'b00);
        chk("t5_gid2", 32'(grant_id), 32'd1); adv();
        look(1'b0, "t5_d91", 1'b1, 8'h91, 1'b1, 2'b10); adv();
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        // Zero inter-frame gap: single-byte frames back to back on dut0.
        z_s_tvalid = 2'b01; z_s_tdata = 16'h0044; z_s_tlast = 2'b01;
        look(1'b1, "t6_idle", 1'b0, 8'h00, 1'b0, 2'b00); adv();
        look(1'b1, "t6_sof", 1'b1, 8'hD5, 1'b0, 2'b00);
        chk("t6_gid", 32'(z_grant_id), 32'd0); adv();
        look(1'b1, "t6_d44", 1'b1, 8'h44, 1'b1, 2'b01); adv();
        z_s_tdata = 16'h0045;
        look(1'b1, "t6_arb", 1'b0, 8'h00, 1'b0, 2'b00);
        chk("t6_fdone", 32'(z_frame_done), 32'd1);
        chk("t6_busy", 32'(z_busy), 32'd0); adv();
        look(1'b1, "t6_sof2", 1'b1, 8'hD5, 1'b0, 2'b00); adv();
        look(1'b1, "t6_d45", 1'b1, 8'h45, 1'b1, 2'b01); adv();
        z_s_tvalid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
